smt_fetch_scheduler: RTL and testbench
======================================

SMT_FETCH_SCHEDULER -- requirements
Module: smt_fetch_scheduler

Interface
REQ-001 SHALL have parameter REDIRECT_PENALTY, default 2, range 1-3: number of cycles a thread is ineligible after a redirect.
REQ-002 SHALL have port i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_Thread_active  input  4  per-thread enable; bit n = thread n.
REQ-005 SHALL have port i_Thread_block  input  4  per-thread fetch block (I-cache miss or long-latency op).
REQ-006 SHALL have port i_Stall  input  1  downstream stall from decode/hazard logic.
REQ-007 SHALL have port i_Redirect  input  1  branch mispredict or redirect strobe, one cycle.
REQ-008 SHALL have port i_Redirect_thread  input  2  thread id of the redirect.
REQ-009 SHALL have port o_Fetch_valid  output  1  the IF stage holds a live fetch this cycle.
REQ-010 SHALL have port o_Fetch_thread  output  2  thread id in IF; drives the PC mux and the thread field of the IF/DEC register.
REQ-011 SHALL have port o_Fetch_onehot  output  4  one-hot decode of o_Fetch_thread, gated by o_Fetch_valid.
REQ-012 SHALL have port o_IfDec_stall  output  1  stall control to the IF/DEC pipeline register.
REQ-013 SHALL have port o_IfDec_flush  output  1  flush control to the IF/DEC pipeline register.
REQ-014 SHALL have port o_Penalty_busy  output  4  per-thread flag: redirect penalty counter nonzero.

Function
REQ-015 SHALL compute eligibility for thread n as: i_Thread_active[n] & ~i_Thread_block[n] & (penalty[n]==0) & ~(i_Redirect & i_Redirect_thread==n).
REQ-016 SHALL keep a 2-bit round-robin pointer last_grant; search order is last_grant+1, +2, +3, +4, all mod 4.
REQ-017 SHALL, on a cycle with i_Stall=0, register the first eligible thread into o_Fetch_thread, set o_Fetch_valid=1 and load last_grant with that thread.
REQ-018 SHALL, on a cycle with i_Stall=0 and no eligible thread, set o_Fetch_valid=0 and hold o_Fetch_thread and last_grant.
REQ-019 SHALL, on a cycle with i_Stall=1, hold o_Fetch_thread, o_Fetch_valid and last_grant, except as REQ-021 requires.
REQ-020 SHALL, on i_Redirect, load penalty[i_Redirect_thread] with REDIRECT_PENALTY, regardless of i_Stall.
REQ-021 SHALL clear o_Fetch_valid on the next edge when i_Redirect=1, o_Fetch_valid=1 and i_Redirect_thread==o_Fetch_thread, even while i_Stall=1.
REQ-022 SHALL decrement each nonzero penalty counter by 1 per cycle, saturating at 0, independent of i_Stall; a reload in the same cycle overrides the decrement.
REQ-023 SHALL drive o_IfDec_stall = i_Stall combinationally, with zero-cycle latency.
REQ-024 SHALL drive o_IfDec_flush combinationally as ~o_Fetch_valid | (i_Redirect & o_Fetch_valid & i_Redirect_thread==o_Fetch_thread).
REQ-025 SHALL rely on the IF/DEC register's stall-over-flush priority; a flush requested during a stall therefore takes effect on the first unstalled cycle through REQ-021 and REQ-024.
REQ-026 SHALL give one-cycle grant latency: eligibility at cycle t determines o_Fetch_thread at cycle t+1.
REQ-027 SHALL never grant the same thread two consecutive times while another thread is eligible.
REQ-028 SHALL grant a lone eligible thread every unstalled cycle.
REQ-029 SHALL make the pointer wrap from 3 to 0 without a bubble.
REQ-030 SHALL drive o_Penalty_busy[n] = (penalty[n]!=0).
REQ-031 SHALL contain no combinational path from i_Thread_* to o_Fetch_*.

Reset
REQ-032 SHALL, when i_Reset=1 at a clock edge, set o_Fetch_valid=0, o_Fetch_thread=0, last_grant=3 and all penalty counters=0; the first grant after reset therefore searches from thread 0.
REQ-033 SHALL give i_Reset priority over redirect, and redirect priority over stall.
REQ-034 SHALL, during reset cycles, drive o_IfDec_flush=1 because o_Fetch_valid=0, and o_IfDec_stall=i_Stall.
REQ-035 SHALL abort all in-flight penalty and grant state on a mid-operation reset, with no residual effect after reset deasserts.

Verification
REQ-036 SHALL cover: all four threads active, no stalls, after reset -> o_Fetch_thread sequence 0,1,2,3,0,1, with o_Fetch_valid=1 from the first cycle after reset.
REQ-037 SHALL cover: i_Thread_active=4'b0101 -> sequence 0,2,0,2; raise i_Thread_block[2] -> 0,0,0.
REQ-038 SHALL cover: thread 1 in IF, i_Stall=1 for 3 cycles -> o_Fetch_thread stays 1 and o_IfDec_stall=1; on release -> next grant is 2.
REQ-039 SHALL cover: redirect for thread 1 while thread 1 is in IF, REDIRECT_PENALTY=2 -> o_IfDec_flush=1 that cycle; thread 1 skipped for the next 2 grant cycles; o_Penalty_busy[1] high for exactly 2 cycles.
REQ-040 SHALL cover: redirect for the thread in IF during i_Stall=1 -> o_Fetch_valid=0 on the next cycle; o_IfDec_flush=1 on the first unstalled cycle.
REQ-041 SHALL cover: i_Thread_active=0 -> o_Fetch_valid=0 and o_IfDec_flush=1 continuously; i_Reset pulse mid-sequence -> next grant is thread 0.

Source files
------------

// File: rtl/smt_fetch_scheduler.sv
// Four-thread SMT fetch scheduler: round-robin thread select into the IF stage,
// per-thread redirect penalty counters and IF/DEC stall/flush control.
module smt_fetch_scheduler #(
    parameter int unsigned REDIRECT_PENALTY = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Thread_active,
    input  logic [3:0] i_Thread_block,
    input  logic       i_Stall,
    input  logic       i_Redirect,
    input  logic [1:0] i_Redirect_thread,
    output logic       o_Fetch_valid,
    output logic [1:0] o_Fetch_thread,
    output logic [3:0] o_Fetch_onehot,
    output logic       o_IfDec_stall,
    output logic       o_IfDec_flush,
    output logic [3:0] o_Penalty_busy
);

    localparam logic [1:0] PENALTY_LOAD = 2'(REDIRECT_PENALTY);

    logic [1:0] penalty      [4];
    logic [1:0] penalty_next [4];
    logic [1:0] last_grant;
    logic [1:0] last_grant_next;
    logic       valid_next;
    logic [1:0] thread_next;
    logic [3:0] eligible;
    logic       grant_found;
    logic [1:0] grant_thread;
    logic       redirect_hits_if;

    assign redirect_hits_if = i_Redirect & o_Fetch_valid & (i_Redirect_thread == o_Fetch_thread);

    always_comb begin
        eligible = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            eligible[n] = i_Thread_active[n] & ~i_Thread_block[n] & (penalty[n] == 2'd0)
                        & ~(i_Redirect & (i_Redirect_thread == 2'(n)));
        end
    end

    // Search starts one past the last grant; offset 4 wraps back onto last_grant itself.
    always_comb begin
        logic [1:0] cand;
        grant_found  = 1'b0;
        grant_thread = last_grant;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found  = 1'b1;
                grant_thread = cand;
            end
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            penalty_next[n] = penalty[n];
            if (i_Redirect && (i_Redirect_thread == 2'(n))) begin
                penalty_next[n] = PENALTY_LOAD;
            end else if (penalty[n] != 2'd0) begin
                penalty_next[n] = penalty[n] - 2'd1;
            end
        end
    end

    always_comb begin
        valid_next      = o_Fetch_valid;
        thread_next     = o_Fetch_thread;
        last_grant_next = last_grant;
        if (!i_Stall) begin
            if (grant_found) begin
                valid_next      = 1'b1;
                thread_next     = grant_thread;
                last_grant_next = grant_thread;
            end else begin
                valid_next = 1'b0;
            end
        end else if (redirect_hits_if) begin
            // Killing the held fetch now makes the flush land on the first unstalled cycle.
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Fetch_valid  <= 1'b0;
            o_Fetch_thread <= 2'd0;
            last_grant     <= 2'd3;
            for (int unsigned n = 0; n < 4; n++) begin
                penalty[n] <= 2'd0;
            end
        end else begin
            o_Fetch_valid  <= valid_next;
            o_Fetch_thread <= thread_next;
            last_grant     <= last_grant_next;
            for (int unsigned n = 0; n < 4; n++) begin
                penalty[n] <= penalty_next[n];
            end
        end
    end

    always_comb begin
        o_Fetch_onehot = '0;
        if (o_Fetch_valid) begin
            o_Fetch_onehot = 4'b0001 << o_Fetch_thread;
        end
        for (int unsigned n = 0; n < 4; n++) begin
            o_Penalty_busy[n] = (penalty[n] != 2'd0);
        end
    end

    assign o_IfDec_stall = i_Stall;
    assign o_IfDec_flush = ~o_Fetch_valid | redirect_hits_if;

endmodule

// File: tb/tb_smt_fetch_scheduler.sv
// Directed and random checks of smt_fetch_scheduler against a cycle-level
// reference model built from the thread-scheduling rules.
module tb_smt_fetch_scheduler;

    localparam int P = 2;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic [3:0] i_Thread_active = '0;
    logic [3:0] i_Thread_block = '0;
    logic       i_Stall = 1'b0;
    logic       i_Redirect = 1'b0;
    logic [1:0] i_Redirect_thread = '0;
    logic       o_Fetch_valid;
    logic [1:0] o_Fetch_thread;
    logic [3:0] o_Fetch_onehot;
    logic       o_IfDec_stall;
    logic       o_IfDec_flush;
    logic [3:0] o_Penalty_busy;

    smt_fetch_scheduler #(.REDIRECT_PENALTY(P)) dut (
        .i_Clk            (i_Clk),
        .i_Reset          (i_Reset),
        .i_Thread_active  (i_Thread_active),
        .i_Thread_block   (i_Thread_block),
        .i_Stall          (i_Stall),
        .i_Redirect       (i_Redirect),
        .i_Redirect_thread(i_Redirect_thread),
        .o_Fetch_valid    (o_Fetch_valid),
        .o_Fetch_thread   (o_Fetch_thread),
        .o_Fetch_onehot   (o_Fetch_onehot),
        .o_IfDec_stall    (o_IfDec_stall),
        .o_IfDec_flush    (o_IfDec_flush),
        .o_Penalty_busy   (o_Penalty_busy)
    );

    always #5 i_Clk = ~i_Clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_known = 0;
    int m_valid, m_thread, m_last;
    int m_pen [4];
    logic pre_flush, pre_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic [3:0] act, input logic [3:0] blk,
                         input logic st, input logic rd, input logic [1:0] rt);
        int n_valid, n_thread, n_last, t;
        int n_pen [4];
        int elig [4];
        logic [3:0] exp_oh, exp_busy;
        logic exp_flush;
        i_Reset = rst; i_Thread_active = act; i_Thread_block = blk;
        i_Stall = st; i_Redirect = rd; i_Redirect_thread = rt;
        #1;
        pre_flush = o_IfDec_flush;
        pre_stall = o_IfDec_stall;
        check("ifdec_stall", {31'b0, o_IfDec_stall}, {31'b0, st});
        if (m_known) begin
            exp_flush = (m_valid == 0) || (rd && int'(rt) == m_thread);
            exp_oh    = (m_valid != 0) ? 4'(1 << m_thread) : 4'b0;
            for (int n = 0; n < 4; n++) exp_busy[n] = (m_pen[n] != 0);
            check("ifdec_flush", {31'b0, o_IfDec_flush}, {31'b0, exp_flush});
            check("fetch_valid", {31'b0, o_Fetch_valid}, 32'(m_valid));
            check("fetch_thread", {30'b0, o_Fetch_thread}, 32'(m_thread));
            check("fetch_onehot", {28'b0, o_Fetch_onehot}, {28'b0, exp_oh});
            check("penalty_busy", {28'b0, o_Penalty_busy}, {28'b0, exp_busy});
        end
        if (rst) begin
            n_valid = 0; n_thread = 0; n_last = 3;
            for (int n = 0; n < 4; n++) n_pen[n] = 0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                elig[n]  = (act[n] && !blk[n] && m_pen[n] == 0 && !(rd && int'(rt) == n)) ? 1 : 0;
                n_pen[n] = (rd && int'(rt) == n) ? P : ((m_pen[n] > 0) ? m_pen[n] - 1 : 0);
            end
            n_valid = m_valid; n_thread = m_thread; n_last = m_last;
            if (!st) begin
                n_valid = 0;
                for (int k = 1; k <= 4; k++) begin
                    t = (m_last + k) % 4;
                    if (elig[t] != 0 && n_valid == 0) begin
                        n_valid = 1; n_thread = t; n_last = t;
                    end
                end
            end else if (rd && m_valid != 0 && int'(rt) == m_thread) begin
                n_valid = 0;
            end
        end
        @(posedge i_Clk);
        if (rst || m_known) begin
            m_known = 1;
            m_valid = n_valid; m_thread = n_thread; m_last = n_last;
            for (int n = 0; n < 4; n++) m_pen[n] = n_pen[n];
        end
        @(negedge i_Clk);
    endtask

    task automatic expect_grant(input string tag, input int thr);
        check({tag, "_valid"}, {31'b0, o_Fetch_valid}, 32'd1);
        check({tag, "_thread"}, {30'b0, o_Fetch_thread}, 32'(thr));
    endtask

    initial begin
        @(negedge i_Clk);

        // reset state
        cycle(1, 4'hF, 4'h0, 0, 0, 2'd0);
        cycle(1, 4'hF, 4'h0, 1, 0, 2'd0);
        check("rst_valid", {31'b0, o_Fetch_valid}, 32'd0);
        check("rst_thread", {30'b0, o_Fetch_thread}, 32'd0);
        check("rst_busy", {28'b0, o_Penalty_busy}, 32'd0);
        check("rst_flush", {31'b0, o_IfDec_flush}, 32'd1);

        // all four active: 0,1,2,3,0,1 with 3->0 wrap
        cycle(1, 4'hF, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("rr4_a", 0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("rr4_b", 1);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("rr4_c", 2);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("rr4_d", 3);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("rr4_e", 0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("rr4_f", 1);

        // threads 0 and 2, then thread 2 blocked
        cycle(1, 4'h5, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'h5, 4'h0, 0, 0, 2'd0); expect_grant("rr2_a", 0);
        cycle(0, 4'h5, 4'h0, 0, 0, 2'd0); expect_grant("rr2_b", 2);
        cycle(0, 4'h5, 4'h0, 0, 0, 2'd0); expect_grant("rr2_c", 0);
        cycle(0, 4'h5, 4'h0, 0, 0, 2'd0); expect_grant("rr2_d", 2);
        cycle(0, 4'h5, 4'h4, 0, 0, 2'd0); expect_grant("lone_a", 0);
        cycle(0, 4'h5, 4'h4, 0, 0, 2'd0); expect_grant("lone_b", 0);
        cycle(0, 4'h5, 4'h4, 0, 0, 2'd0); expect_grant("lone_c", 0);

        // stall holds thread 1, release grants 2
        cycle(1, 4'hF, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("pre_stall", 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'hF, 4'h0, 1, 0, 2'd0);
            check("stall_out", {31'b0, pre_stall}, 32'd1);
            expect_grant("stall_hold", 1);
        end
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("stall_rel", 2);

        // redirect thread 1 while in IF, threads 0/1 active
        cycle(1, 4'h3, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0); expect_grant("rd_pre", 1);
        cycle(0, 4'h3, 4'h0, 0, 1, 2'd1);
        check("rd_flush", {31'b0, pre_flush}, 32'd1);
        expect_grant("rd_g0", 0); check("rd_busy0", {31'b0, o_Penalty_busy[1]}, 32'd1);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0);
        expect_grant("rd_g1", 0); check("rd_busy1", {31'b0, o_Penalty_busy[1]}, 32'd1);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0);
        expect_grant("rd_g2", 0); check("rd_busy2", {31'b0, o_Penalty_busy[1]}, 32'd0);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0); expect_grant("rd_g3", 1);

        // redirect during stall
        cycle(1, 4'h3, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0); expect_grant("rds_pre", 1);
        cycle(0, 4'h3, 4'h0, 1, 1, 2'd1);
        check("rds_kill", {31'b0, o_Fetch_valid}, 32'd0);
        cycle(0, 4'h3, 4'h0, 1, 0, 2'd0);
        check("rds_hold", {31'b0, o_Fetch_valid}, 32'd0);
        cycle(0, 4'h3, 4'h0, 0, 0, 2'd0);
        check("rds_flush", {31'b0, pre_flush}, 32'd1);
        expect_grant("rds_g", 0);

        // no active threads
        cycle(1, 4'h0, 4'h0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'h0, 4'h0, 0, 0, 2'd0);
            check("idle_valid", {31'b0, o_Fetch_valid}, 32'd0);
            check("idle_flush", {31'b0, pre_flush}, 32'd1);
        end

        // mid-sequence reset with a redirect in flight
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0);
        cycle(0, 4'hF, 4'h0, 0, 1, 2'd3);
        cycle(1, 4'hF, 4'h0, 0, 1, 2'd3);
        check("mid_rst_busy", {28'b0, o_Penalty_busy}, 32'd0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("mid_rst_a", 0);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("mid_rst_b", 1);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("mid_rst_c", 2);
        cycle(0, 4'hF, 4'h0, 0, 0, 2'd0); expect_grant("mid_rst_d", 3);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
